// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a one-cycle response/unpause pulse.
// Optional access statistics are compiled in with `define DMEM_RESP_STATS_EN.
module dmem_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [XLEN/8-1:0]   req_wstrb,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [4:0]          resp_rd,
    output logic                resp_err,
`ifdef DMEM_RESP_STATS_EN
    output logic [31:0]         stat_loads,
    output logic [31:0]         stat_stores,
    output logic [31:0]         stat_errs,
`endif
    output logic                unpause
);

    localparam int NB = XLEN / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            wr_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [NB-1:0]   wstrb_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] rdata_q;
    logic [4:0]      rd_out_q;
    logic            err_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            access;

    // Access fields come straight from the request when the access happens at acceptance (LATENCY=0).
    logic            acc_write;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [NB-1:0]   acc_wstrb;
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_idx;
    logic [AW-1:0]   mem_idx;
    logic            acc_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = CW'(LATENCY);
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
            acc_rd    = req_rd;
        end else begin
            acc_write = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
            acc_rd    = rd_q;
        end
        acc_idx = {2'b00, acc_addr[XLEN-1:2]};
        mem_idx = acc_idx[AW-1:0];
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_idx >= XLEN'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rd_q     <= '0;
            rdata_q  <= '0;
            rd_out_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                rd_q    <= req_rd;
            end
            if (access) begin
                err_q    <= acc_err;
                rd_out_q <= acc_rd;
                rdata_q  <= (!acc_err && !acc_write) ? mem[mem_idx] : '0;
            end
        end
    end

    // Array has no reset; an aborted transaction never reaches the access edge so nothing is written.
    always_ff @(posedge clk) begin
        if (access && acc_write && !acc_err) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_wstrb[b]) begin
                    mem[mem_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_RESP_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (access) begin
            if (acc_err) begin
                if (errs_q != 32'hFFFF_FFFF) errs_q <= errs_q + 32'd1;
            end else if (acc_write) begin
                if (stores_q != 32'hFFFF_FFFF) stores_q <= stores_q + 32'd1;
            end else begin
                if (loads_q != 32'hFFFF_FFFF) loads_q <= loads_q + 32'd1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign unpause    = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = rd_out_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence, a LATENCY=0 instance for the zero-wait case.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        valid2, valid0;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [4:0]  req_rd;

    logic        ready2, rvalid2, rerr2, unp2;
    logic [31:0] rdata2;
    logic [4:0]  rrd2;
    logic        ready0, rvalid0, rerr0, unp0;
    logic [31:0] rdata0;
    logic [4:0]  rrd0;
`ifdef DMEM_RESP_STATS_EN
    logic [31:0] sl2, ss2, se2, sl0, ss0, se0;
`endif

    int vectors;
    int miscompares;

    int          cap_lat;
    logic [31:0] cap_rdata;
    logic [4:0]  cap_rd;
    logic        cap_err;
    logic        cap_unp;

    dmem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(valid2), .req_ready(ready2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rd(req_rd),
        .resp_valid(rvalid2), .resp_rdata(rdata2), .resp_rd(rrd2), .resp_err(rerr2),
`ifdef DMEM_RESP_STATS_EN
        .stat_loads(sl2), .stat_stores(ss2), .stat_errs(se2),
`endif
        .unpause(unp2)
    );

    dmem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(valid0), .req_ready(ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rd(req_rd),
        .resp_valid(rvalid0), .resp_rdata(rdata0), .resp_rd(rrd0), .resp_err(rerr0),
`ifdef DMEM_RESP_STATS_EN
        .stat_loads(sl0), .stat_stores(ss0), .stat_errs(se0),
`endif
        .unpause(unp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and captures the first response seen within a bounded window.
    task automatic do_req(input bit sel0, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [4:0] rd);
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        req_rd    = rd;
        if (sel0) valid0 = 1'b1; else valid2 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid2 = 1'b0;
        cap_lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((sel0 ? rvalid0 : rvalid2) === 1'b1) begin
                cap_lat   = i;
                cap_rdata = sel0 ? rdata0 : rdata2;
                cap_rd    = sel0 ? rrd0   : rrd2;
                cap_err   = sel0 ? rerr0  : rerr2;
                cap_unp   = sel0 ? unp0   : unp2;
                break;
            end
        end
    endtask

    int acc_cyc[3];
    int resp_cyc[3];
    logic [4:0] resp_tag[3];
    logic rdy_hist[24];
    int n_acc, n_resp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        valid2    = 1'b0;
        valid0    = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_rd    = '0;

        // 1. reset
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready2}, 32'd1);
        chk("rst_valid", {31'b0, rvalid2}, 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_err", {31'b0, rerr2}, 32'd0);
        chk("rst_unpause", {31'b0, unp2}, 32'd0);
        chk("rst_rd", {27'b0, rrd2}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready2}, 32'd1);

        // 2. store then load, LATENCY=2
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 5'd0);
        chk("st_lat", cap_lat, 32'd3);
        chk("st_err", {31'b0, cap_err}, 32'd0);
        chk("st_rdata", cap_rdata, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 5'd5);
        chk("ld_lat", cap_lat, 32'd3);
        chk("ld_rdata", cap_rdata, 32'hDEADBEEF);
        chk("ld_rd", {27'b0, cap_rd}, 32'd5);
        chk("ld_unpause", {31'b0, cap_unp}, 32'd1);
        @(negedge clk);
        chk("ld_pulse_end", {30'b0, rvalid2, unp2}, 32'd0);
        chk("ld_hold_rdata", rdata2, 32'hDEADBEEF);

        // 3. byte strobe
        do_req(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 5'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 5'd6);
        chk("strb_rdata", cap_rdata, 32'hDEADBEAA);

        // 4. errors
        do_req(1'b0, 1'b0, 32'h12, 32'h0, 4'h0, 5'd7);
        chk("mis_ld_err", {31'b0, cap_err}, 32'd1);
        chk("mis_ld_rdata", cap_rdata, 32'd0);
        do_req(1'b0, 1'b1, 32'h12, 32'h11223344, 4'hF, 5'd0);
        chk("mis_st_err", {31'b0, cap_err}, 32'd1);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 5'd8);
        chk("mis_st_nowrite", cap_rdata, 32'hDEADBEAA);
        chk("ok_err_clear", {31'b0, cap_err}, 32'd0);
        do_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 5'd9);
        chk("oor_ld_err", {31'b0, cap_err}, 32'd1);
        chk("oor_ld_rdata", cap_rdata, 32'd0);

        // 5. back-to-back loads with req_valid held
        n_acc  = 0;
        n_resp = 0;
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_wstrb = 4'h0;
        req_rd    = 5'd1;
        valid2    = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            rdy_hist[c] = ready2;
            if (rvalid2 === 1'b1 && n_resp < 3) begin
                resp_cyc[n_resp] = c;
                resp_tag[n_resp] = rrd2;
                n_resp++;
            end
            if (ready2 === 1'b1 && valid2 && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 3) valid2 = 1'b0;
                else req_rd = 5'(n_acc + 1);
            end
        end
        chk("b2b_n_acc", n_acc, 32'd3);
        chk("b2b_n_resp", n_resp, 32'd3);
        if (n_acc == 3 && n_resp == 3) begin
            chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd4);
            chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd4);
            chk("b2b_busy_rdy", {29'b0, rdy_hist[acc_cyc[0]+1], rdy_hist[acc_cyc[0]+2],
                                 rdy_hist[acc_cyc[0]+3]}, 32'd0);
            chk("b2b_resp0_cyc", resp_cyc[0] - acc_cyc[0], 32'd3);
            chk("b2b_order", {17'b0, resp_tag[0], resp_tag[1], resp_tag[2]},
                {17'b0, 5'd1, 5'd2, 5'd3});
        end

        // 6. reset during WAIT drops the store
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_wstrb = 4'hF;
        valid2    = 1'b1;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        @(negedge clk);
        chk("wait_ready", {31'b0, ready2}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready2}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", {31'b0, rvalid2}, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 5'd10);
        chk("abort_nowrite", cap_rdata, 32'hDEADBEAA);

        // reset while RESP clears the pulse at once
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_rd    = 5'd11;
        valid2    = 1'b1;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_before_rst", {31'b0, rvalid2}, 32'd1);
        rst = 1'b0;
        #1;
        chk("resp_rst_valid", {30'b0, rvalid2, unp2}, 32'd0);
        chk("resp_rst_rdata", rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LATENCY=0 instance
        do_req(1'b1, 1'b1, 32'h0, 32'h12345678, 4'hF, 5'd0);
        chk("l0_st_lat", cap_lat, 32'd1);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd12);
        chk("l0_ld_lat", cap_lat, 32'd1);
        chk("l0_ld_rdata", cap_rdata, 32'h12345678);
        chk("l0_ld_rd", {27'b0, cap_rd}, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
